// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: load-use stall, multi-cycle
// MUL hold in EX, deferred branch flush and EX operand forwarding selects.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic [2:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       ex_hold,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  typedef struct packed {
    logic       wr;
    logic       is_load;
    logic       is_mul;
    logic [2:0] rd;
  } stage_t;

  typedef enum logic {RUN, MUL_BUSY} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       pending_flush;
  logic       flush_eff;
  logic       load_use;
  logic       accept;

  logic       id_rd_rs1, id_rd_rs2;
  stage_t     id_dec;

  logic       vld_p0, vld_p1, vld_p2;
  stage_t     ex_p0, mem_p1, wb_p2;
  logic [2:0] ex_rs1_p0, ex_rs2_p0;

  // MEM result wins over WB; a LOAD in MEM has no data yet, r0 is never a source
  function automatic logic [1:0] fwd_sel(input logic [2:0] rs,
                                         input logic mvld, input stage_t mem,
                                         input logic wvld, input stage_t wb);
    if (mvld && mem.wr && mem.rd != 3'd0 && !mem.is_load && mem.rd == rs)
      return 2'b01;
    else if (wvld && wb.wr && wb.rd != 3'd0 && wb.rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    id_rd_rs1      = (id_opcode != OP_NOP);
    id_rd_rs2      = (id_opcode != OP_NOP) && (id_opcode != OP_LOAD);
    id_dec.wr      = (id_opcode != OP_NOP) && (id_opcode != OP_STORE);
    id_dec.is_load = (id_opcode == OP_LOAD);
    id_dec.is_mul  = (id_opcode == OP_MUL);
    id_dec.rd      = id_rd;
  end

  assign flush_eff = flush | pending_flush;
  assign load_use  = id_valid & vld_p0 & ex_p0.is_load & (ex_p0.rd != 3'd0) &
                     ((id_rd_rs1 & (ex_p0.rd == id_rs1)) |
                      (id_rd_rs2 & (ex_p0.rd == id_rs2)));
  assign accept    = id_valid & ~flush_eff & ~load_use;
  assign stall     = ex_hold | (load_use & ~flush_eff);

  // A MUL sits in EX for three cycles; only the first two hold the pipe
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ex_hold   = 1'b0;
    case (state)
      RUN: begin
        if (vld_p0 && ex_p0.is_mul) begin
          ex_hold   = 1'b1;
          state_nxt = MUL_BUSY;
          cnt_nxt   = 2'd1;
        end
      end
      MUL_BUSY: begin
        if (cnt == 2'd1) begin
          ex_hold = 1'b1;
          cnt_nxt = 2'd0;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (vld_p0) begin
      fwd_a = fwd_sel(ex_rs1_p0, vld_p1, mem_p1, vld_p2, wb_p2);
      if (!ex_p0.is_load)
        fwd_b = fwd_sel(ex_rs2_p0, vld_p1, mem_p1, vld_p2, wb_p2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= RUN;
      cnt           <= 2'd0;
      pending_flush <= 1'b0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ex_hold) begin
        if (flush)
          pending_flush <= 1'b1;
        vld_p1 <= 1'b0;
      end else begin
        pending_flush <= 1'b0;
        vld_p0        <= accept;
        vld_p1        <= vld_p0;
      end
      vld_p2 <= vld_p1;
    end
  end

  // ID -> EX (p0) -> MEM (p1) -> WB (p2)
  always_ff @(posedge clk) begin
    if (!ex_hold) begin
      ex_p0     <= id_dec;
      ex_rs1_p0 <= id_rs1;
      ex_rs2_p0 <= id_rs2;
      mem_p1    <= ex_p0;
    end
    wb_p2 <= mem_p1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vectors with hand-derived expected
// outputs, queued when driven and compared half a cycle later.
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] LD  = 4'd8;
  localparam logic [3:0] ST  = 4'd9;
  localparam logic [3:0] MUL = 4'd10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_opcode = 4'd0;
  logic [2:0] id_rs1 = 3'd0, id_rs2 = 3'd0, id_rd = 3'd0;
  logic       flush = 1'b0;
  logic       stall, ex_hold;
  logic [1:0] fwd_a, fwd_b;

  pipe_hazard_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .id_valid (id_valid),
    .id_opcode(id_opcode),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_rd    (id_rd),
    .flush    (flush),
    .stall    (stall),
    .ex_hold  (ex_hold),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       chk;
    logic       rstn;
    logic       v;
    logic [3:0] op;
    logic [2:0] rs1, rs2, rd;
    logic       fl;
    logic       st, eh;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t cy(string name, logic v, logic [3:0] op,
                              logic [2:0] rs1, logic [2:0] rs2, logic [2:0] rd,
                              logic fl, logic st, logic eh,
                              logic [1:0] fa, logic [1:0] fb);
    vec_t t;
    t.name = name; t.chk = 1'b1; t.rstn = 1'b1;
    t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.fl = fl;
    t.st = st; t.eh = eh; t.fa = fa; t.fb = fb;
    return t;
  endfunction

  function automatic vec_t nochk(string name, logic r);
    vec_t t;
    t = cy(name, 1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    t.chk = 1'b0;
    t.rstn = r;
    return t;
  endfunction

  task automatic step(input vec_t t);
    vec_t e;
    @(posedge clk);
    #1;
    rstn = t.rstn; id_valid = t.v; id_opcode = t.op;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; flush = t.fl;
    sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      checks++;
      if ({stall, ex_hold, fwd_a, fwd_b} !== {e.st, e.eh, e.fa, e.fb}) begin
        failures++;
        $display("FAIL %s: got stall=%b ex_hold=%b fwd_a=%b fwd_b=%b, want stall=%b ex_hold=%b fwd_a=%b fwd_b=%b",
                 e.name, stall, ex_hold, fwd_a, fwd_b, e.st, e.eh, e.fa, e.fb);
      end
    end
  endtask

  task automatic drain();
    repeat (3) step(nochk("drain", 1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // reset, then single-issue forwarding / load-use vectors
    tbl.push_back(nochk("rst", 1'b0));
    tbl.push_back(nochk("rst", 1'b0));
    tbl.push_back(cy("reset_state", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // ADD r3 ; ADD rs1=r3 -> MEM forward
    tbl.push_back(cy("memfwd_c0", 1, ADD, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("memfwd_c1", 1, ADD, 3, 4, 5, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("memfwd_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
    tbl.push_back(cy("memfwd_c3", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // ADD r3 ; NOP ; ADD rs1=r3 -> WB forward
    tbl.push_back(cy("wbfwd_c0", 1, ADD, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("wbfwd_c1", 1, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("wbfwd_c2", 1, ADD, 3, 6, 4, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("wbfwd_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00));
    // r5 in both MEM and WB -> MEM priority on both operands
    tbl.push_back(cy("prio_c0", 1, ADD, 1, 2, 5, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("prio_c1", 1, ADD, 3, 4, 5, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("prio_c2", 1, ADD, 5, 5, 6, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("prio_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01));
    // STORE has no destination
    tbl.push_back(cy("store_c0", 1, ST, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("store_c1", 1, ADD, 3, 3, 1, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("store_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // writes to r0 are never forwarded
    tbl.push_back(cy("r0_c0", 1, ADD, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("r0_c1", 1, ADD, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("r0_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // LOAD in EX never takes an rs2 forward
    tbl.push_back(cy("ldrs2_c0", 1, ADD, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("ldrs2_c1", 1, LD, 4, 3, 5, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("ldrs2_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    // LOAD r2 ; ADD rs2=r2 -> one stall, bubble, then WB forward
    tbl.push_back(cy("lu_c0", 1, LD, 1, 0, 2, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("lu_stall", 1, ADD, 5, 2, 6, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(cy("lu_bubble", 1, ADD, 5, 2, 6, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("lu_fwd", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
    // LOAD r0 ; ADD rs2=r0 -> no stall
    tbl.push_back(cy("lu0_c0", 1, LD, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("lu0_c1", 1, ADD, 5, 0, 6, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(cy("lu0_c2", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      if (i + 1 < tbl.size() && tbl[i + 1].name.substr(0, 1) != tbl[i].name.substr(0, 1)
          && tbl[i].rstn)
        drain();
    end
    drain();

    // MUL r4 ; ADD rs1=r4: two hold cycles, then MEM forward
    step(cy("mul_c0", 1, MUL, 1, 2, 4, 0, 0, 0, 2'b00, 2'b00));
    step(cy("mul_h1", 1, ADD, 4, 7, 5, 0, 1, 1, 2'b00, 2'b00));
    step(cy("mul_h2", 1, ADD, 4, 7, 5, 0, 1, 1, 2'b00, 2'b00));
    step(cy("mul_rel", 1, ADD, 4, 7, 5, 0, 0, 0, 2'b00, 2'b00));
    step(cy("mul_fwd", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
    drain();

    // back-to-back MULs: second re-enters the hold with no idle cycle
    step(cy("mm_c0", 1, MUL, 1, 2, 4, 0, 0, 0, 2'b00, 2'b00));
    step(cy("mm_h1", 1, MUL, 4, 5, 6, 0, 1, 1, 2'b00, 2'b00));
    step(cy("mm_h2", 1, MUL, 4, 5, 6, 0, 1, 1, 2'b00, 2'b00));
    step(cy("mm_rel", 1, MUL, 4, 5, 6, 0, 0, 0, 2'b00, 2'b00));
    step(cy("mm_h3", 0, NOP, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00));
    step(cy("mm_h4", 0, NOP, 0, 0, 0, 0, 1, 1, 2'b10, 2'b00));
    step(cy("mm_rel2", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(cy("mm_idle", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    drain();

    // flush coinciding with load-use: flush wins, ADD r7 never reaches MEM
    step(cy("fl_c0", 1, LD, 1, 0, 2, 0, 0, 0, 2'b00, 2'b00));
    step(cy("fl_lu", 1, ADD, 2, 3, 7, 1, 0, 0, 2'b00, 2'b00));
    step(cy("fl_c2", 1, ADD, 7, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    step(cy("fl_c3", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(cy("fl_c4", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    drain();

    // flush during MUL hold: ADD r5 dropped when the hold ends
    step(cy("flm_c0", 1, MUL, 1, 2, 4, 0, 0, 0, 2'b00, 2'b00));
    step(cy("flm_h1", 1, ADD, 3, 3, 5, 1, 1, 1, 2'b00, 2'b00));
    step(cy("flm_h2", 1, ADD, 3, 3, 5, 0, 1, 1, 2'b00, 2'b00));
    step(cy("flm_rel", 1, ADD, 3, 3, 5, 0, 0, 0, 2'b00, 2'b00));
    step(cy("flm_c4", 1, ADD, 5, 4, 1, 0, 0, 0, 2'b00, 2'b00));
    step(cy("flm_ex", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
    drain();

    // reset in the second MUL_BUSY cycle
    step(cy("rsm_c0", 1, MUL, 1, 2, 4, 0, 0, 0, 2'b00, 2'b00));
    step(cy("rsm_h1", 0, NOP, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
    step(cy("rsm_h2", 0, NOP, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
    step(nochk("rsm_rst", 1'b0));
    step(cy("rsm_post", 1, ADD, 4, 1, 3, 0, 0, 0, 2'b00, 2'b00));
    step(cy("rsm_c5", 1, ADD, 3, 0, 2, 0, 0, 0, 2'b00, 2'b00));
    step(cy("rsm_fwd", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
    drain();

    // reset in the first MUL_BUSY cycle leaves no residual hold
    step(cy("rs1_c0", 1, MUL, 1, 2, 4, 0, 0, 0, 2'b00, 2'b00));
    step(cy("rs1_h1", 0, NOP, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
    step(nochk("rs1_rst", 1'b0));
    step(cy("rs1_post", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    step(cy("rs1_post2", 0, NOP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
